// File: rtl/sensor_sequencer_pkg.sv
// rtl/sensor_sequencer_pkg.sv - shared constants and state encodings for the sensor sequencer
package sensor_sequencer_pkg;

  localparam int N_CH_DEF  = 6;
  localparam int CNT_W_DEF = 16;

  // Channel indices, matching the en_bits ordering used by the timing manager
  localparam int CH_EDDY0 = 0;
  localparam int CH_EDDY1 = 1;
  localparam int CH_EDDY2 = 2;
  localparam int CH_EDDY3 = 3;
  localparam int CH_ENC   = 4;
  localparam int CH_ADC   = 5;

  typedef enum logic {
    TOP_IDLE,
    TOP_RUN
  } top_state_t;

  typedef enum logic [2:0] {
    CH_OFF,
    CH_WAIT_DELAY,
    CH_WAIT_DONE,
    CH_DONE,
    CH_TMO
  } ch_state_t;

endpackage

// File: rtl/sensor_sequencer_channel.sv
// rtl/sensor_sequencer_channel.sv - per-channel start/watchdog/done FSM
module seq_channel
  import sensor_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_launch,
  input  logic             i_enable,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_elapsed,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_timeout,
  input  logic             i_done,
  output logic             o_start,
  output logic             o_expire,
  output logic             o_finished
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_t        r_state;
  logic [CNT_W-1:0] r_wd;
  logic             r_done_q;

  logic w_rise;
  logic w_hit;
  logic w_imm_exp;
  logic w_wd_exp;

  // r_wd counts cycles since the start pulse (1 in the cycle after it), so the
  // channel lands in TMO exactly timeout cycles after start
  assign w_rise     = i_done & ~r_done_q;
  assign w_hit      = (r_state == CH_WAIT_DELAY) && (i_elapsed == i_delay);
  assign w_imm_exp  = w_hit && (i_timeout == ONE);
  assign w_wd_exp   = (r_state == CH_WAIT_DONE) && (i_timeout != '0) &&
                      (r_wd == i_timeout - ONE) && !w_rise;
  assign o_start    = w_hit;
  assign o_expire   = w_imm_exp | w_wd_exp;
  assign o_finished = (r_state == CH_DONE) || (r_state == CH_TMO);

  // Channel FSM, watchdog counter and done edge-detector flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CH_OFF;
      r_wd     <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= i_done;
      if (i_launch) begin
        r_state <= i_enable ? CH_WAIT_DELAY : CH_OFF;
        r_wd    <= '0;
      end else if (i_stop) begin
        r_state <= CH_OFF;
      end else begin
        case (r_state)
          CH_WAIT_DELAY: begin
            if (w_hit) begin
              r_wd    <= ONE;
              r_state <= w_imm_exp ? CH_TMO : CH_WAIT_DONE;
            end
          end
          CH_WAIT_DONE: begin
            if (w_rise) begin
              r_state <= CH_DONE;
            end else if (w_wd_exp) begin
              r_state <= CH_TMO;
            end else if (r_wd != '1) begin
              r_wd <= r_wd + ONE;
            end
          end
          CH_OFF, CH_DONE, CH_TMO: r_state <= r_state;
          default: r_state <= CH_OFF;
        endcase
      end
    end
  end

endmodule

// File: rtl/sensor_sequencer.sv
// rtl/sensor_sequencer.sv - per-trigger acquisition sequencer for eddy/encoder/ADC sensors
module sensor_sequencer
  import sensor_sequencer_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger,
  input  logic [N_CH-1:0]       en_bits,
  input  logic [N_CH*CNT_W-1:0] delay,
  input  logic [CNT_W-1:0]      timeout,
  input  logic [N_CH-1:0]       done_in,
  input  logic                  clear_status,
  output logic [N_CH-1:0]       start_out,
  output logic                  busy,
  output logic                  cycle_done,
  output logic [N_CH-1:0]       active_mask,
  output logic [N_CH-1:0]       timeout_flags,
  output logic                  overrun
);

  top_state_t       r_state;
  logic [CNT_W-1:0] r_elapsed;
  logic [N_CH-1:0]  r_active_mask;
  logic [N_CH-1:0]  r_tflags;
  logic             r_overrun;

  logic            w_accept;
  logic            w_busy;
  logic            w_all_fin;
  logic [N_CH-1:0] w_fin;
  logic [N_CH-1:0] w_expire;

  assign w_busy    = (r_state == TOP_RUN);
  assign w_accept  = (r_state == TOP_IDLE) && trigger && (en_bits != '0);
  assign w_all_fin = &(w_fin | ~r_active_mask);

  assign busy          = w_busy;
  assign cycle_done    = w_busy && w_all_fin;
  assign active_mask   = r_active_mask;
  assign timeout_flags = r_tflags;
  assign overrun       = r_overrun;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    seq_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_launch   (w_accept),
      .i_enable   (en_bits[g]),
      .i_stop     (cycle_done),
      .i_elapsed  (r_elapsed),
      .i_delay    (delay[g*CNT_W +: CNT_W]),
      .i_timeout  (timeout),
      .i_done     (done_in[g]),
      .o_start    (start_out[g]),
      .o_expire   (w_expire[g]),
      .o_finished (w_fin[g])
    );
  end

  // Top FSM: accept a trigger, run the saturating elapsed counter, end when all channels finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= TOP_IDLE;
      r_elapsed     <= '0;
      r_active_mask <= '0;
    end else begin
      case (r_state)
        TOP_IDLE: begin
          if (w_accept) begin
            r_state       <= TOP_RUN;
            r_active_mask <= en_bits;
            r_elapsed     <= '0;
          end
        end
        TOP_RUN: begin
          if (w_all_fin) begin
            r_state <= TOP_IDLE;
          end
          if (r_elapsed != '1) begin
            r_elapsed <= r_elapsed + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Sticky status flags; a set in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tflags  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_tflags  <= (r_tflags & ~{N_CH{clear_status}}) | w_expire;
      r_overrun <= (r_overrun & ~clear_status) | (w_busy & trigger);
    end
  end

endmodule

// File: doc/sensor_sequencer.md
# sensor_sequencer

Per-trigger acquisition sequencer between the PWM-synchronised trigger of the timing manager and the sensor interfaces (eddy-current 0..3, encoder, ADC). On each trigger it latches the enable mask, then issues a one-cycle start pulse to each enabled sensor after that sensor's programmed delay. It waits for each sensor's done edge under a watchdog, reports timeouts and trigger overruns as sticky flags, and pulses `cycle_done` when every enabled channel has either completed or timed out.

## Interface
Parameters:
- `N_CH`, 6, number of sensor channels; bit order is eddy0..3, encoder, ADC.
- `CNT_W`, 16, width of the delay, timeout and elapsed counters.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  one-cycle pulse that starts a sequence.
- `en_bits`  in  N_CH  channel enables; sampled only on an accepted trigger.
- `delay`  in  N_CH*CNT_W  per-channel start delay in clk cycles; channel i occupies bits [i*CNT_W +: CNT_W].
- `timeout`  in  CNT_W  watchdog limit in cycles, measured from the start pulse; 0 disables the watchdog.
- `done_in`  in  N_CH  sensor done levels; only rising edges count.
- `clear_status`  in  1  one-cycle pulse that clears the sticky flags.
- `start_out`  out  N_CH  one-cycle start pulse per channel.
- `busy`  out  1  high while a sequence is running.
- `cycle_done`  out  1  one-cycle pulse when a sequence ends.
- `active_mask`  out  N_CH  enable mask latched for the current or last sequence.
- `timeout_flags`  out  N_CH  sticky per-channel watchdog expiry.
- `overrun`  out  1  sticky flag: a trigger arrived while `busy` was high.

## Operation
- Top FSM states:
  - IDLE to RUN on `trigger` when `en_bits` is not 0. In that cycle: latch `active_mask`, clear `elapsed`, and send every enabled channel to WAIT_DELAY.
  - A trigger with `en_bits` of 0 is ignored. No flag is set and no `cycle_done` is issued.
  - RUN to IDLE when every enabled channel is in DONE or TMO. `cycle_done` is asserted for that single cycle.
- Elapsed counter:
  - `elapsed` is CNT_W wide and increments every cycle in RUN.
  - It saturates at all-ones and does not wrap.
- Per-channel FSM states: OFF, WAIT_DELAY, WAIT_DONE, DONE, TMO.
  - WAIT_DELAY: when `elapsed` equals `delay[i]`, pulse `start_out[i]`, clear the channel watchdog counter, and go to WAIT_DONE.
  - WAIT_DONE: a `done_in[i]` rising edge moves the channel to DONE. If `timeout` is not 0 and the watchdog reaches `timeout`, set `timeout_flags[i]` and move to TMO.
  - If the done edge and the watchdog expiry land in the same cycle, done wins.
  - Done edges outside WAIT_DONE are ignored. This covers a stale done from the previous sequence.
- Disabled channels stay in OFF and never pulse `start_out`.
- A delay value the saturated counter cannot reach is not special-cased. The channel starts when the counter saturates at that value.
- Trigger while `busy`: set `overrun`. The running sequence continues unaffected.
- Sticky flags:
  - `clear_status` clears `timeout_flags` and `overrun`.
  - If a set and a clear land in the same cycle, the set wins.
- Reset, including mid-sequence: all FSMs return to IDLE/OFF, counters and flags clear, and no further pulses are emitted.

## Timing
- Every output resets to 0.
- Trigger accepted at cycle T:
  - `busy` is high from T+1 through the cycle `cycle_done` is asserted, inclusive. It is low in the next cycle.
  - Channel i with delay d pulses `start_out[i]` at cycle T+1+d.
- `done_in` rising edge:
  - The edge is detected with a one-flop edge detector.
  - For a `done_in` rise sampled at cycle D, the channel is in DONE at D+1.
  - The earliest `cycle_done` is D+1, when that channel is the last one to finish.
- Watchdog: with the start pulse at cycle S and no done edge, the channel enters TMO and sets its flag at S+`timeout`.
- Back-to-back sequences: a trigger in the same cycle as `cycle_done` counts as an overrun. A trigger one cycle after `cycle_done` is accepted.
- `delay` and `timeout` must be held stable while `busy` is high. The block does not latch them.

## Structure
- Shared package holds:
  - the `N_CH` default;
  - channel index constants (EDDY0..3 = 0..3, ENC = 4, ADC = 5), matching the existing `en_bits` ordering;
  - the top-FSM and channel-FSM state encodings.
- One sub-module, `seq_channel`: the per-channel FSM, watchdog counter and done-edge detector. It is instantiated `N_CH` times in a generate loop.
- The top level keeps the top FSM, `elapsed`, the sticky flags and the all-finished reduction.

## Test plan
- Single channel, eddy0 only, delay 0, timeout 0. Trigger at T, `done_in[0]` rises at T+10. Expect `start_out[0]` at T+1, `cycle_done` at T+11, `busy` low at T+12.
- All six channels enabled with delays 0, 5, 10, 15, 20, 25. Expect start pulses at T+1, T+6, …, T+26. Expect `cycle_done` one cycle after the last done edge.
- Watchdog, timeout 8. The ADC never completes and eddy0 completes. Expect `timeout_flags[5]` set at start+8 and a `cycle_done` pulse. Then `clear_status` gives flags equal to 0.
- Second trigger while `busy`. Expect `overrun` set and start pulses only for the first sequence. `clear_status` in the same cycle as a new overrun leaves `overrun` set.
- Stale done: `done_in[4]` is held high across the trigger and rises again only later. The channel waits for the new edge. Expect the done edge and watchdog expiry in the same cycle to yield DONE with no flag set.
- Reset asserted mid-RUN. Outputs go to 0 immediately; after release, a trigger with `en_bits` of 0 produces no `busy` and no `cycle_done`.
